pdn_power_sequencer: RTL and testbench
======================================

PDN_POWER_SEQUENCER -- requirements
Module: pdn_power_sequencer

Interface
REQ-001 Parameter NUM_DOM, default 6: number of supply domains sequenced (VDD1..VDDn); legal range 1..32.
REQ-002 Parameter TMO_CYC, default 1000: clock cycles allowed for a domain's pgood to rise after its enable is asserted.
REQ-003 Parameter SETTLE_CYC, default 16: settle cycles after pgood before the next domain is enabled; also the per-domain off-delay.
REQ-004 clk  input  1  single sequencer clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 pwr_up_req  input  1  level request to bring all domains up.
REQ-007 pwr_dn_req  input  1  level request to bring all domains down; has priority over pwr_up_req.
REQ-008 pgood  input  NUM_DOM  per-domain power-good, already synchronised to clk.
REQ-009 fault_clr  input  1  single-cycle pulse that clears a latched fault.
REQ-010 dom_en  output  NUM_DOM  per-domain supply enable, registered.
REQ-011 busy  output  1  high while ramping up or down.
REQ-012 all_on  output  1  high only in state ON.
REQ-013 fault  output  1  latched fault flag.
REQ-014 fault_idx  output  $clog2(NUM_DOM) (min 1)  index of the domain that caused the fault.

Function
REQ-015 FSM states SHALL be: IDLE, UP_WAIT, UP_SETTLE, ON, DN_WAIT, FAULT.
REQ-016 IDLE + pwr_up_req=1 + pwr_dn_req=0 -> UP_WAIT, idx=0, dom_en[0] set in the same edge.
REQ-017 UP_WAIT: pgood[idx]=1 -> UP_SETTLE, timer loaded with SETTLE_CYC; timer reaching TMO_CYC without pgood[idx] -> FAULT, fault_idx=idx.
REQ-018 UP_SETTLE: after exactly SETTLE_CYC cycles, if idx<NUM_DOM-1 then idx+1, dom_en[idx+1] set, -> UP_WAIT; else -> ON.
REQ-019 Domains SHALL power up in ascending index order; never more than one domain in UP_WAIT at a time.
REQ-020 ON: any pgood[i]=0 with dom_en[i]=1 -> FAULT, fault_idx=lowest such i.
REQ-021 pwr_dn_req=1 in ON, UP_WAIT or UP_SETTLE -> DN_WAIT, starting at the highest enabled index; that domain's dom_en cleared on the same edge.
REQ-022 DN_WAIT: after SETTLE_CYC cycles, or earlier if pgood[idx]=0, clear dom_en[idx-1] and decrement; when index 0 has been cleared and waited out -> IDLE.
REQ-023 Domains SHALL power down in descending index order; pgood behaviour in DN_WAIT SHALL never raise a fault.
REQ-024 FAULT entry: all dom_en cleared on the same edge (emergency off); fault=1; stays in FAULT until fault_clr=1 -> IDLE, fault=0; fault_idx holds its value until the next fault.
REQ-025 pwr_up_req while in DN_WAIT or FAULT SHALL be ignored; it takes effect only from IDLE.
REQ-026 fault_clr outside FAULT SHALL have no effect.
REQ-027 busy=1 in UP_WAIT, UP_SETTLE and DN_WAIT; all_on=1 only in ON; both are registered, consistent with the current state.
REQ-028 Timer SHALL saturate, never wrap; width is $clog2(max(TMO_CYC,SETTLE_CYC)+1).
REQ-029 NUM_DOM=1 SHALL work: ON is reached after one UP_WAIT/UP_SETTLE pass.

Reset
REQ-030 rst_n=0 SHALL immediately force: state IDLE, dom_en all 0, busy 0, all_on 0, fault 0, fault_idx 0, idx 0, timer 0.
REQ-031 Reset asserted mid-ramp SHALL drop all enables asynchronously; after release the block waits in IDLE for a fresh pwr_up_req.

Structure
REQ-032 Shared package pdn_pkg SHALL hold the state enum type and the default parameter constants.
REQ-033 One sub-module, pdn_timer: loadable saturating down-counter with done flag, reset by the same clk/rst_n.

Verification
REQ-034 NUM_DOM=6, SETTLE=16; pwr_up_req held, each pgood rises 5 cycles after its dom_en -> dom_en fills 0..5 in order, 21-cycle spacing, all_on=1, busy=0.
REQ-035 In ON, pwr_dn_req=1 with pgood following dom_en -> dom_en clears 5..0 in order, then IDLE, no fault.
REQ-036 pgood[3] held low, TMO=1000 -> FAULT exactly 1000 cycles after dom_en[3]; dom_en=0 next cycle; fault_idx=3; fault_clr -> IDLE.
REQ-037 In ON, pgood[2] drops -> dom_en=0 on the next edge, fault=1, fault_idx=2.
REQ-038 rst_n pulsed low in UP_SETTLE of domain 4 -> outputs 0 asynchronously; no enable until a new pwr_up_req.
REQ-039 pwr_up_req and pwr_dn_req both high in UP_WAIT of domain 2 -> DN_WAIT; dom_en[2] then [1] then [0] clear; ends in IDLE.

Source files
------------

// File: rtl/pdn_pkg.sv
// Shared types and defaults for the PDN power sequencer.
// Holds the FSM state enum, default parameters and width helpers.
package pdn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UP_WAIT,
    UP_SETTLE,
    ON,
    DN_WAIT,
    FAULT
  } pdn_state_e;

  localparam int DEF_NUM_DOM    = 6;
  localparam int DEF_TMO_CYC    = 1000;
  localparam int DEF_SETTLE_CYC = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int tmr_w(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 0) ? $clog2(m + 1) : 1;
  endfunction

endpackage

// File: rtl/pdn_timer.sv
// Loadable saturating down-counter with a done flag (count == 0).
// Ports: clk, rst_n, load_i, val_i[W] in; done_o out.
module pdn_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/pdn_power_sequencer.sv
// Sequences NUM_DOM supply domains up in ascending and down in
// descending order, with pgood timeout and in-service fault latching.
// Ports: clk, rst_n, pwr_up_req, pwr_dn_req, pgood[N], fault_clr in;
//        dom_en[N], busy, all_on, fault, fault_idx out.
module pdn_power_sequencer
  import pdn_pkg::*;
#(
  parameter int NUM_DOM    = DEF_NUM_DOM,
  parameter int TMO_CYC    = DEF_TMO_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  localparam int IW = idx_w(NUM_DOM)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pwr_up_req,
  input  logic               pwr_dn_req,
  input  logic [NUM_DOM-1:0] pgood,
  input  logic               fault_clr,
  output logic [NUM_DOM-1:0] dom_en,
  output logic               busy,
  output logic               all_on,
  output logic               fault,
  output logic [IW-1:0]      fault_idx
);

  localparam int TW = tmr_w(TMO_CYC, SETTLE_CYC);

  // Timer is loaded with N-1 so the exit edge lands N cycles later.
  localparam logic [TW-1:0] TMO_LD =
    TW'((TMO_CYC > 0) ? TMO_CYC - 1 : 0);
  localparam logic [TW-1:0] SET_LD =
    TW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [IW-1:0] LAST = IW'(NUM_DOM - 1);

  pdn_state_e state_q, state_d;

  logic [IW-1:0]      idx_q, idx_d;
  logic [NUM_DOM-1:0] en_q, en_d;
  logic               flt_q, flt_d;
  logic [IW-1:0]      fidx_q, fidx_d;
  logic               busy_q, busy_d;
  logic               on_q, on_d;

  logic               ld;
  logic [TW-1:0]      ld_val;
  logic               tmr_done;

  logic [NUM_DOM-1:0] sel;
  logic [NUM_DOM-1:0] drop;
  logic [IW-1:0]      low_idx;
  logic               pg_sel;

  pdn_timer #(
    .W (TW)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (ld),
    .val_i  (ld_val),
    .done_o (tmr_done)
  );

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_DOM; i++) begin
      sel[i] = (idx_q == IW'(i));
    end
  end

  assign pg_sel = |(pgood & sel);
  assign drop   = en_q & ~pgood;

  // Scan downward so the lowest failing domain is reported.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_DOM - 1; i >= 0; i--) begin
      if (drop[i]) begin
        low_idx = IW'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    en_d    = en_q;
    flt_d   = flt_q;
    fidx_d  = fidx_q;
    ld      = 1'b0;
    ld_val  = '0;

    unique case (state_q)
      IDLE: begin
        if (pwr_up_req && !pwr_dn_req) begin
          state_d = UP_WAIT;
          idx_d   = '0;
          en_d    = NUM_DOM'(1);
          ld      = 1'b1;
          ld_val  = TMO_LD;
        end
      end

      UP_WAIT: begin
        if (pwr_dn_req) begin
          state_d = DN_WAIT;
          en_d    = en_q & ~sel;
          ld      = 1'b1;
          ld_val  = SET_LD;
        end else if (pg_sel) begin
          state_d = UP_SETTLE;
          ld      = 1'b1;
          ld_val  = SET_LD;
        end else if (tmr_done) begin
          state_d = FAULT;
          en_d    = '0;
          flt_d   = 1'b1;
          fidx_d  = idx_q;
        end
      end

      UP_SETTLE: begin
        if (pwr_dn_req) begin
          state_d = DN_WAIT;
          en_d    = en_q & ~sel;
          ld      = 1'b1;
          ld_val  = SET_LD;
        end else if (tmr_done) begin
          if (idx_q != LAST) begin
            state_d = UP_WAIT;
            idx_d   = idx_q + 1'b1;
            en_d    = en_q | (sel << 1);
            ld      = 1'b1;
            ld_val  = TMO_LD;
          end else begin
            state_d = ON;
          end
        end
      end

      ON: begin
        // A lost rail outranks an orderly shutdown request.
        if (|drop) begin
          state_d = FAULT;
          en_d    = '0;
          flt_d   = 1'b1;
          fidx_d  = low_idx;
        end else if (pwr_dn_req) begin
          state_d = DN_WAIT;
          en_d    = en_q & ~sel;
          ld      = 1'b1;
          ld_val  = SET_LD;
        end
      end

      DN_WAIT: begin
        if (tmr_done || !pg_sel) begin
          if (idx_q == '0) begin
            state_d = IDLE;
          end else begin
            idx_d  = idx_q - 1'b1;
            en_d   = en_q & ~(sel >> 1);
            ld     = 1'b1;
            ld_val = SET_LD;
          end
        end
      end

      FAULT: begin
        if (fault_clr) begin
          state_d = IDLE;
          flt_d   = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        en_d    = '0;
      end
    endcase
  end

  assign busy_d = (state_d == UP_WAIT) ||
                  (state_d == UP_SETTLE) ||
                  (state_d == DN_WAIT);
  assign on_d   = (state_d == ON);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      en_q    <= '0;
      flt_q   <= 1'b0;
      fidx_q  <= '0;
      busy_q  <= 1'b0;
      on_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      flt_q   <= flt_d;
      fidx_q  <= fidx_d;
      busy_q  <= busy_d;
      on_q    <= on_d;
    end
  end

  assign dom_en    = en_q;
  assign busy      = busy_q;
  assign all_on    = on_q;
  assign fault     = flt_q;
  assign fault_idx = fidx_q;

endmodule

// File: tb/tb_pdn_power_sequencer.sv
// Scoreboard bench for pdn_power_sequencer (6 domains, plus a
// 1-domain instance). Expected output changes are queued with cycles.
module tb_pdn_power_sequencer;

  localparam int PG_DLY = 5;

  typedef struct {
    string      tag;
    int         cy;
    logic [5:0] en;
    logic       busy;
    logic       on;
    logic       flt;
    logic [2:0] fidx;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       up, dn, fclr;
  logic [5:0] pgood, pg_ok, pg_kill;
  logic [5:0] dom_en;
  logic       busy, all_on, fault;
  logic [2:0] fault_idx;

  logic       up1, pg1;
  logic [0:0] dom_en1;
  logic       busy1, all_on1, fault1;
  logic [0:0] fidx1;

  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;
  int  age[6];
  ev_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Rail model: pgood rises PG_DLY cycles after enable, drops with it.
  always @(negedge clk) begin
    for (int i = 0; i < 6; i++) begin
      pg_ok[i] <= dom_en[i] && (age[i] >= PG_DLY - 1);
      if (!dom_en[i]) age[i] <= 0;
      else if (age[i] < PG_DLY) age[i] <= age[i] + 1;
    end
  end

  assign pgood = pg_ok & ~pg_kill;

  pdn_power_sequencer #(
    .NUM_DOM    (6),
    .TMO_CYC    (1000),
    .SETTLE_CYC (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwr_up_req (up),
    .pwr_dn_req (dn),
    .pgood      (pgood),
    .fault_clr  (fclr),
    .dom_en     (dom_en),
    .busy       (busy),
    .all_on     (all_on),
    .fault      (fault),
    .fault_idx  (fault_idx)
  );

  pdn_power_sequencer #(
    .NUM_DOM    (1),
    .TMO_CYC    (8),
    .SETTLE_CYC (4)
  ) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwr_up_req (up1),
    .pwr_dn_req (1'b0),
    .pgood      (pg1),
    .fault_clr  (fclr),
    .dom_en     (dom_en1),
    .busy       (busy1),
    .all_on     (all_on1),
    .fault      (fault1),
    .fault_idx  (fidx1)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input string tag, input int cy,
                      input logic [5:0] en, input logic b,
                      input logic o, input logic f,
                      input logic [2:0] fi);
    ev_t e;
    e.tag = tag; e.cy = cy; e.en = en;
    e.busy = b; e.on = o; e.flt = f; e.fidx = fi;
    q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Expected power-up events for domains 0..last, issued at cycle c.
  task automatic push_up(input int c, input int last,
                         input logic [2:0] fi);
    for (int k = 0; k <= last; k++) begin
      push($sformatf("up_en%0d", k), c + 1 + 21 * k,
           6'((7'd1 << (k + 1)) - 7'd1), 1'b1, 1'b0, 1'b0, fi);
    end
  endtask

  task automatic monitor();
    logic [11:0] prev, cur, exp;
    ev_t e;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = {dom_en, busy, all_on, fault, fault_idx};
      if (rst_n && cur !== prev) begin
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected: cyc %0d got %0h expected none",
                   cyc, cur);
        end else begin
          e = q.pop_front();
          exp = {e.en, e.busy, e.on, e.flt, e.fidx};
          if (cur !== exp || cyc != e.cy) begin
            n_fail++;
            $display("FAIL %s: got %0h at cyc %0d expected %0h at %0d",
                     e.tag, cur, cyc, exp, e.cy);
          end
        end
      end
      prev = cur;
    end
  endtask

  task automatic stimulus();
    int c;
    int e;
    rst_n = 1'b0; up = 0; dn = 0; fclr = 0;
    pg_kill = '0; up1 = 0; pg1 = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_en", 32'(dom_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_on", 32'(all_on), 0);
    chk("rst_flt", 32'(fault), 0);
    chk("rst_fidx", 32'(fault_idx), 0);

    // Single-domain instance; its fault_clr pulse also hits idle dut.
    c = cyc; up1 = 1; pg1 = 1;
    wait_cyc(c + 5);
    chk("d1_settle_on", 32'(all_on1), 0);
    chk("d1_settle_busy", 32'(busy1), 1);
    chk("d1_en", 32'(dom_en1), 1);
    wait_cyc(c + 6);
    chk("d1_on", 32'(all_on1), 1);
    chk("d1_on_busy", 32'(busy1), 0);
    pg1 = 0;
    wait_cyc(c + 7);
    chk("d1_flt", 32'(fault1), 1);
    chk("d1_flt_en", 32'(dom_en1), 0);
    up1 = 0; fclr = 1;
    wait_cyc(c + 8);
    fclr = 0;
    chk("d1_clr", 32'(fault1), 0);
    wait_cyc(c + 12);

    // Full power-up.
    c = cyc; up = 1;
    push_up(c, 5, 3'd0);
    push("up_on", c + 127, 6'h3f, 1'b0, 1'b1, 1'b0, 3'd0);
    wait_cyc(c + 140);

    // Orderly power-down with pgood following enables.
    c = cyc; dn = 1;
    push("dn5", c + 1, 6'h1f, 1'b1, 1'b0, 1'b0, 3'd0);
    push("dn4", c + 2, 6'h0f, 1'b1, 1'b0, 1'b0, 3'd0);
    push("dn3", c + 3, 6'h07, 1'b1, 1'b0, 1'b0, 3'd0);
    push("dn2", c + 4, 6'h03, 1'b1, 1'b0, 1'b0, 3'd0);
    push("dn1", c + 5, 6'h01, 1'b1, 1'b0, 1'b0, 3'd0);
    push("dn0", c + 6, 6'h00, 1'b1, 1'b0, 1'b0, 3'd0);
    push("dn_idle", c + 7, 6'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    wait_cyc(c + 12);
    dn = 0; up = 0;
    wait_cyc(c + 15);

    // In-service loss of domain 2.
    c = cyc; up = 1;
    push_up(c, 5, 3'd0);
    push("on2", c + 127, 6'h3f, 1'b0, 1'b1, 1'b0, 3'd0);
    wait_cyc(c + 135);
    e = cyc; pg_kill[2] = 1; up = 0;
    push("drop2", e + 1, 6'h00, 1'b0, 1'b0, 1'b1, 3'd2);
    wait_cyc(e + 5);
    pg_kill[2] = 0; fclr = 1;
    push("clr2", e + 6, 6'h00, 1'b0, 1'b0, 1'b0, 3'd2);
    wait_cyc(e + 6);
    fclr = 0;
    wait_cyc(e + 10);

    // Domain 3 never reports good: timeout after 1000 cycles.
    pg_kill[3] = 1;
    c = cyc; up = 1;
    push_up(c, 3, 3'd2);
    push("tmo3", c + 1064, 6'h00, 1'b0, 1'b0, 1'b1, 3'd3);
    wait_cyc(c + 1100);
    up = 0; fclr = 1;
    push("clr3", c + 1101, 6'h00, 1'b0, 1'b0, 1'b0, 3'd3);
    wait_cyc(c + 1101);
    fclr = 0; pg_kill[3] = 0;
    wait_cyc(c + 1105);

    // Asynchronous reset while domain 4 is settling.
    c = cyc; up = 1;
    push_up(c, 4, 3'd3);
    wait_cyc(c + 95);
    up = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_en", 32'(dom_en), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_flt_idx", 32'(fault_idx), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    c = cyc;
    wait_cyc(c + 40);
    chk("arst_hold_en", 32'(dom_en), 0);

    // Both requests in UP_WAIT of domain 2: down wins.
    c = cyc; up = 1;
    push_up(c, 2, 3'd0);
    wait_cyc(c + 45);
    dn = 1;
    push("both2", c + 46, 6'h03, 1'b1, 1'b0, 1'b0, 3'd0);
    push("both1", c + 47, 6'h01, 1'b1, 1'b0, 1'b0, 3'd0);
    push("both0", c + 48, 6'h00, 1'b1, 1'b0, 1'b0, 3'd0);
    push("both_idle", c + 49, 6'h00, 1'b0, 1'b0, 1'b0, 3'd0);
    wait_cyc(c + 55);
    up = 0; dn = 0;

    c = cyc;
    while (q.size() != 0 && cyc < c + 50) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    disable fork;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
